// File: rtl/mp_addsub_pkg.sv
// Shared types and helpers for the multi-precision add/sub sequencer.
// Optional feature macro used by the sequencer: MP_ADDSUB_ZFLAG_EN (zero flag port z_o).
package mp_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of the limb counter; at least one bit even when K = 1.
   function automatic int cnt_w(input int k);
      int w;
      w = $clog2(k);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/mp_addsub_seq_cla.sv
// M-bit carry-lookahead adder/subtractor built from 4-bit lookahead groups.
// sub_i = 1 computes a - b (carry-in forced to 1); otherwise a + b + cin_i.
module mp_addsub_seq_cla #(
   parameter int M = 16
) (
   input  logic [M-1:0] a_i,
   input  logic [M-1:0] b_i,
   input  logic         sub_i,
   input  logic         cin_i,
   output logic [M-1:0] sum_o,
   output logic         cout_o,
   output logic         ovf_o
);

   localparam int NG = M / 4;

   logic [M-1:0] b_s;
   logic [M-1:0] g_s;
   logic [M-1:0] p_s;
   logic [M:0]   c_s;

   // Generate/propagate per bit, carries resolved per 4-bit group and chained between groups.
   always_comb begin
      b_s    = b_i ^ {M{sub_i}};
      g_s    = a_i & b_s;
      p_s    = a_i ^ b_s;
      c_s    = '0;
      c_s[0] = cin_i | sub_i;
      for (int gi = 0; gi < NG; gi++) begin
         c_s[4*gi+1] = g_s[4*gi] | (p_s[4*gi] & c_s[4*gi]);
         c_s[4*gi+2] = g_s[4*gi+1]
                     | (p_s[4*gi+1] & g_s[4*gi])
                     | (p_s[4*gi+1] & p_s[4*gi] & c_s[4*gi]);
         c_s[4*gi+3] = g_s[4*gi+2]
                     | (p_s[4*gi+2] & g_s[4*gi+1])
                     | (p_s[4*gi+2] & p_s[4*gi+1] & g_s[4*gi])
                     | (p_s[4*gi+2] & p_s[4*gi+1] & p_s[4*gi] & c_s[4*gi]);
         c_s[4*gi+4] = g_s[4*gi+3]
                     | (p_s[4*gi+3] & g_s[4*gi+2])
                     | (p_s[4*gi+3] & p_s[4*gi+2] & g_s[4*gi+1])
                     | (p_s[4*gi+3] & p_s[4*gi+2] & p_s[4*gi+1] & g_s[4*gi])
                     | (p_s[4*gi+3] & p_s[4*gi+2] & p_s[4*gi+1] & p_s[4*gi] & c_s[4*gi]);
      end
      sum_o  = p_s ^ c_s[M-1:0];
      cout_o = c_s[M];
      ovf_o  = c_s[M] ^ c_s[M-1];
   end

endmodule

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/sub sequencer: one W = M*K bit operation streamed as K limbs,
// LS limb first, through a single M-bit CLA with the carry held in a register.
// Optional: define MP_ADDSUB_ZFLAG_EN to add the zero-result flag port z_o.
module mp_addsub_seq
   import mp_addsub_pkg::*;
#(
   parameter int M = 16,
   parameter int K = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           in_valid_i,
   output logic           in_ready_o,
   input  logic           sub_i,
   input  logic           cin_i,
   input  logic [M*K-1:0] x_i,
   input  logic [M*K-1:0] y_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic [M*K-1:0] out_o,
   output logic           cout_o,
   output logic           v_o
`ifdef MP_ADDSUB_ZFLAG_EN
  ,output logic           z_o
`endif
);

   localparam int W  = M * K;
   localparam int CW = cnt_w(K);
   localparam logic [CW-1:0] LAST_CNT = CW'(K - 1);

   state_e        state_q;
   logic          in_ready_q;
   logic          out_valid_q;
   logic [W-1:0]  x_q;
   logic [W-1:0]  yn_q;
   logic [W-1:0]  out_q;
   logic          c_q;
   logic [CW-1:0] cnt_q;
   logic          cout_q;
   logic          v_q;

   logic [M-1:0]   limb_sum_s;
   logic           limb_cout_s;
   logic           limb_ovf_s;
   logic [W+M-1:0] out_cat_s;
   logic           limb_zero_s;

   // The adder always adds; subtraction is folded into yn_q and the initial carry.
   mp_addsub_seq_cla #(.M(M)) u_cla (
      .a_i    (x_q[M-1:0]),
      .b_i    (yn_q[M-1:0]),
      .sub_i  (1'b0),
      .cin_i  (c_q),
      .sum_o  (limb_sum_s),
      .cout_o (limb_cout_s),
      .ovf_o  (limb_ovf_s)
   );

   // New limb enters at the MS end so after K shifts the result is fully aligned.
   assign out_cat_s   = {limb_sum_s, out_q};
   assign limb_zero_s = (limb_sum_s == '0);

`ifdef MP_ADDSUB_ZFLAG_EN
   logic zacc_q;

   // Zero accumulator: starts at 1 on accept and clears on any non-zero limb.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         zacc_q <= 1'b0;
      end else if (state_q == IDLE && in_valid_i) begin
         zacc_q <= 1'b1;
      end else if (state_q == RUN) begin
         zacc_q <= zacc_q & limb_zero_s;
      end else begin
         zacc_q <= zacc_q;
      end
   end

   assign z_o = zacc_q;
`else
   logic unused_zero_s;
   assign unused_zero_s = limb_zero_s;
`endif

   // Control FSM with datapath shift registers, carry chain register and result flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         x_q         <= '0;
         yn_q        <= '0;
         out_q       <= '0;
         c_q         <= 1'b0;
         cnt_q       <= '0;
         cout_q      <= 1'b0;
         v_q         <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  x_q        <= x_i;
                  yn_q       <= y_i ^ {W{sub_i}};
                  c_q        <= sub_i | cin_i;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end else begin
                  state_q    <= IDLE;
               end
            end
            RUN: begin
               out_q <= out_cat_s[W+M-1:M];
               x_q   <= x_q >> M;
               yn_q  <= yn_q >> M;
               c_q   <= limb_cout_s;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST_CNT) begin
                  cout_q      <= limb_cout_s;
                  v_q         <= limb_ovf_s;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  state_q     <= RUN;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  state_q     <= DONE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_o       = out_q;
   assign cout_o      = cout_q;
   assign v_o         = v_q;

endmodule
